vector_mem_sequencer: RTL and testbench
=======================================

# vector_mem_sequencer

Memory-stage controller that serializes one vector load or store into per-lane scalar accesses on a single byte-wide data-memory port. It sits after the EX/MEM pipeline register, takes its memory-control and data outputs, and holds the pipeline with a stall while the R lanes are transferred one element per handshake. Load results are returned as a packed vector for the MEM/WB stage.

## Interface
- I, 32, address width
- N, 8, lane element width (must equal the memory data width)
- R, 6, number of vector lanes
- T, 16, ack timeout in cycles (used only with VMEM_TIMEOUT_EN)

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  vector store request from EX/MEM
- MemtoRegM  in  1  vector load request from EX/MEM
- AddressM  in  I  base address of lane 0
- WriteDataM  in  R×N  store data; lane k in slice k
- StallM  out  1  freeze the upstream pipeline registers
- DoneM  out  1  one-cycle pulse when the operation completes
- ErrorM  out  1  timeout flag (0 without VMEM_TIMEOUT_EN)
- ReadDataM  out  R×N  gathered load data
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  I  lane address
- mem_wdata  out  N  lane write data
- mem_rdata  in  N  read data, valid while mem_ack = 1
- mem_ack  in  1  access accepted / completed

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - If MemWriteM or MemtoRegM is 1, latch op type (store has priority if both are 1), AddressM and WriteDataM.
  - Clear lane counter and ErrorM, then go to ACCESS.
- **ACCESS:**
  - Drive mem_req = 1, mem_we = op, mem_addr = base + lane, mem_wdata = latched lane data.
  - Address sum is modulo 2^I; wrap past all-ones is legal.
  - On mem_ack = 1 for a load, write mem_rdata into ReadDataM[lane].
  - If lane = R-1, go to DONE; otherwise increment lane.
  - mem_req stays high across lane changes.
- **DONE:** StallM = 0 and DoneM = 1 for one cycle, then IDLE.
- **StallM** = (IDLE and request present) or ACCESS. It is combinational from state and inputs.
- **ReadDataM:**
  - Holds its value between operations.
  - A store leaves it unchanged.
  - Lanes not yet loaded keep their old values.
- **Reset** (any time, including mid-operation): state = IDLE, lane = 0, and all outputs go to 0 immediately (mem_req, StallM, DoneM, ErrorM, ReadDataM, mem_addr, mem_wdata, mem_we). A partially completed burst is abandoned.

## Timing
- **Handshake:**
  - mem_addr, mem_we and mem_wdata are stable while mem_req = 1 and mem_ack = 0.
  - Zero-wait ack (ack in the same cycle as the request) is allowed.
  - The lane advances on the edge that samples ack.
- **Zero-wait latency:**
  - Request seen in IDLE at cycle 0.
  - ACCESS covers cycles 1..R.
  - DONE is at cycle R+1.
  - StallM is high for cycles 0..R, i.e. R+1 stall cycles.
  - Each wait cycle adds one stall cycle.
- **Back-to-back:** a new request is seen in the IDLE cycle that follows DONE, so there is exactly one non-stalled cycle (DONE) between operations.
- mem_ack while not in ACCESS is ignored.

## Configuration
- **VMEM_TIMEOUT_EN defined:**
  - A per-lane wait counter resets on every lane advance.
  - If T consecutive ACCESS cycles pass without ack, drop mem_req, set ErrorM = 1 and go to DONE.
  - ErrorM stays 1 until the next operation starts or reset.
  - The remaining lanes are not accessed.
- **Not defined:** no counter; ACCESS waits indefinitely; ErrorM is tied to 0.

## Test plan
- Reset low mid-ACCESS at lane 3 -> next cycle: mem_req = 0, StallM = 0, state IDLE, ReadDataM = 0.
- Store, AddressM = 0x100, lanes 0x11..0x66, zero-wait ack -> writes 0x11@0x100 … 0x66@0x105; StallM high for 7 cycles; DoneM at cycle 7.
- Load, AddressM = 0xFFFFFFFE, memory returns 0xA0+k with 2 wait cycles per lane -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0..0x3; ReadDataM = {0xA5..0xA0}; 19 stall cycles.
- MemWriteM = MemtoRegM = 1 -> mem_we = 1 for all 6 lanes.
- Two stores back-to-back -> one DoneM cycle with StallM = 0 between them; the second base address is latched in the following IDLE.
- VMEM_TIMEOUT_EN, T = 16, ack withheld on lane 2 -> mem_req drops after 16 cycles; ErrorM = 1; DoneM pulses; lanes 3..5 are never requested.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// Serializes one vector load/store into R byte-wide scalar memory accesses, stalling the pipeline meanwhile.
// Optional ack timeout is compiled in with `define VMEM_TIMEOUT_EN.
module vector_mem_sequencer #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6,
  parameter int T = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemWriteM,
  input  logic           MemtoRegM,
  input  logic [I-1:0]   AddressM,
  input  logic [R*N-1:0] WriteDataM,
  output logic           StallM,
  output logic           DoneM,
  output logic           ErrorM,
  output logic [R*N-1:0] ReadDataM,
  output logic           mem_req,
  output logic           mem_we,
  output logic [I-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  input  logic [N-1:0]   mem_rdata,
  input  logic           mem_ack
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   lane;
  logic [I-1:0]    base;
  logic [R*N-1:0]  wdata_q;
  logic            op_we;
  logic            req_in;

  assign req_in = MemWriteM | MemtoRegM;

  // Gated by reset so the stall releases the instant reset is asserted.
  assign StallM = reset & (((state == IDLE) & req_in) | (state == ACCESS));

`ifdef VMEM_TIMEOUT_EN
  localparam int WW = $clog2(T + 1);
  logic [WW-1:0] wcnt;
`else
  assign ErrorM = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lane      <= '0;
      base      <= '0;
      wdata_q   <= '0;
      op_we     <= 1'b0;
      DoneM     <= 1'b0;
      ReadDataM <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef VMEM_TIMEOUT_EN
      ErrorM    <= 1'b0;
      wcnt      <= '0;
`endif
    end else begin
      DoneM <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in) begin
            op_we     <= MemWriteM;
            base      <= AddressM;
            wdata_q   <= WriteDataM;
            lane      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= AddressM;
            mem_wdata <= WriteDataM[N-1:0];
            state     <= ACCESS;
`ifdef VMEM_TIMEOUT_EN
            ErrorM    <= 1'b0;
            wcnt      <= '0;
`endif
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!op_we) ReadDataM[int'(lane)*N +: N] <= mem_rdata;
`ifdef VMEM_TIMEOUT_EN
            wcnt <= '0;
`endif
            if (lane == LW'(R - 1)) begin
              mem_req <= 1'b0;
              DoneM   <= 1'b1;
              state   <= DONE;
            end else begin
              // Next lane's address/data are registered here so they are stable for the whole request.
              lane      <= lane + 1'b1;
              mem_addr  <= base + I'(lane) + I'(1);
              mem_wdata <= wdata_q[(int'(lane) + 1)*N +: N];
            end
          end
`ifdef VMEM_TIMEOUT_EN
          else if (wcnt == WW'(T - 1)) begin
            mem_req <= 1'b0;
            ErrorM  <= 1'b1;
            DoneM   <= 1'b1;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: directed vector ops, memory model, decoupled monitor.
// The timeout case is exercised only when VMEM_TIMEOUT_EN is defined.
module tb_vector_mem_sequencer;

  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           MemWriteM, MemtoRegM;
  logic [I-1:0]   AddressM;
  logic [R*N-1:0] WriteDataM;
  logic           StallM, DoneM, ErrorM;
  logic [R*N-1:0] ReadDataM;
  logic           mem_req, mem_we;
  logic [I-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata;
  logic [N-1:0]   mem_rdata;
  logic           mem_ack;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         we;
    logic [I-1:0] addr;
    logic [N-1:0] wdata;
  } lane_t;

  typedef struct packed {
    logic [R*N-1:0] rd;
    logic           err;
  } done_t;

  lane_t lane_q[$];
  done_t done_q[$];

  int           waits = 0;
  int           wcnt_m = 0;
  logic [I-1:0] rd_base = '0;
  logic [N-1:0] rd_seed = '0;
  logic         hold_en = 1'b0;
  logic [I-1:0] hold_addr = '0;

  vector_mem_sequencer #(.I(I), .N(N), .R(R), .T(16)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .AddressM(AddressM), .WriteDataM(WriteDataM),
    .StallM(StallM), .DoneM(DoneM), .ErrorM(ErrorM), .ReadDataM(ReadDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: acks after `waits` wait cycles, returns rd_seed + offset from rd_base.
  always @(posedge clk) begin
    #2;
    if (reset && mem_req) begin
      mem_rdata = rd_seed + N'(mem_addr - rd_base);
      if (hold_en && mem_addr == hold_addr) begin
        mem_ack = 1'b0;
      end else if (wcnt_m >= waits) begin
        mem_ack = 1'b1;
        wcnt_m  = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt_m++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt_m  = 0;
    end
  end

  // Monitor: every accepted lane and every completion is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_req && mem_ack) begin
        if (lane_q.size() == 0) begin
          chk("unexpected_access", {mem_we, mem_addr, mem_wdata}, '0);
        end else begin
          lane_t e;
          e = lane_q.pop_front();
          chk("lane_access", {mem_we, mem_addr, mem_wdata}, {e.we, e.addr, e.wdata});
        end
      end
      if (DoneM) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(ReadDataM), '1);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_readdata", 64'(ReadDataM), 64'(d.rd));
          chk("done_error", 64'(ErrorM), 64'(d.err));
        end
      end
    end
  end

  task automatic push_lanes(input logic we, input logic [I-1:0] b,
                            input logic [R*N-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      lane_t e;
      e.we    = we;
      e.addr  = b + I'(k);
      e.wdata = d[k*N +: N];
      lane_q.push_back(e);
    end
  endtask

  task automatic push_done(input logic [R*N-1:0] rd, input logic err);
    done_t d;
    d.rd  = rd;
    d.err = err;
    done_q.push_back(d);
  endtask

  task automatic start_op(input logic w, input logic r, input logic [I-1:0] a,
                          input logic [R*N-1:0] d);
    @(posedge clk);
    #1;
    MemWriteM  = w;
    MemtoRegM  = r;
    AddressM   = a;
    WriteDataM = d;
  endtask

  // Cycle 0 is the IDLE cycle presenting the request; counts stalled cycles until DoneM.
  task automatic wait_done(input int exp_stall, input int exp_cyc, input bit hold, input string nm);
    int stalls = 0;
    bit seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (DoneM) begin
        seen = 1;
        chk({nm, "_done_cycle"}, 64'(c), 64'(exp_cyc));
        chk({nm, "_stall_at_done"}, 64'(StallM), 64'(0));
        chk({nm, "_req_at_done"}, 64'(mem_req), 64'(0));
      end else if (StallM) begin
        stalls++;
      end
      if (!seen && c == 0 && !hold) begin
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 64'(0), 64'(1));
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
  endtask

  initial begin
    reset = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
    AddressM = '0; WriteDataM = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {StallM, DoneM, ErrorM, mem_req, mem_we}, '0);
    chk("rst_readdata", 64'(ReadDataM), '0);
    chk("rst_addr", 64'({mem_addr, mem_wdata}), '0);
    @(posedge clk); #1; reset = 1'b1;

    // Load interrupted by reset while lane 3 is being requested.
    waits = 0; rd_base = 32'h200; rd_seed = 8'h10;
    push_lanes(1'b0, 32'h200, 48'h0, 3);
    start_op(1'b0, 1'b1, 32'h200, 48'h0);
    @(posedge clk); #1; MemtoRegM = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst_req", 64'(mem_req), 64'(0));
    chk("midrst_stall", 64'(StallM), 64'(0));
    chk("midrst_done", 64'(DoneM), 64'(0));
    chk("midrst_readdata", 64'(ReadDataM), 64'(0));
    @(posedge clk); #1; reset = 1'b1;
    chk("midrst_lanes_seen", 64'(lane_q.size()), 64'(0));

    // Zero-wait store.
    push_lanes(1'b1, 32'h100, 48'h665544332211, R);
    push_done(48'h0, 1'b0);
    start_op(1'b1, 1'b0, 32'h100, 48'h665544332211);
    wait_done(7, 7, 0, "store");

    // Load wrapping the address space, 2 wait cycles per lane.
    waits = 2; rd_base = 32'hFFFFFFFE; rd_seed = 8'hA0;
    push_lanes(1'b0, 32'hFFFFFFFE, 48'h123456789ABC, R);
    push_done(48'hA5A4A3A2A1A0, 1'b0);
    start_op(1'b0, 1'b1, 32'hFFFFFFFE, 48'h123456789ABC);
    wait_done(19, 19, 0, "load_wrap");

    // Both request flags: store wins, ReadDataM untouched.
    waits = 0;
    push_lanes(1'b1, 32'h300, 48'h0F0E0D0C0B0A, R);
    push_done(48'hA5A4A3A2A1A0, 1'b0);
    start_op(1'b1, 1'b1, 32'h300, 48'h0F0E0D0C0B0A);
    wait_done(7, 7, 0, "both");

    // Back-to-back stores; second address changes during DONE and is latched in IDLE.
    push_lanes(1'b1, 32'h500, 48'hC6C5C4C3C2C1, R);
    push_done(48'hA5A4A3A2A1A0, 1'b0);
    push_lanes(1'b1, 32'h600, 48'hD6D5D4D3D2D1, R);
    push_done(48'hA5A4A3A2A1A0, 1'b0);
    start_op(1'b1, 1'b0, 32'h500, 48'hC6C5C4C3C2C1);
    wait_done(7, 7, 1, "b2b_first");
    AddressM   = 32'h600;
    WriteDataM = 48'hD6D5D4D3D2D1;
    wait_done(7, 7, 0, "b2b_second");

`ifdef VMEM_TIMEOUT_EN
    // Ack withheld on lane 2: 16 wait cycles then abort with ErrorM.
    rd_base = 32'h400; rd_seed = 8'h50;
    hold_en = 1'b1; hold_addr = 32'h402;
    push_lanes(1'b0, 32'h400, 48'h0, 2);
    push_done(48'hA5A4A3A25150, 1'b1);
    start_op(1'b0, 1'b1, 32'h400, 48'h0);
    wait_done(19, 19, 0, "timeout");
    @(negedge clk);
    chk("timeout_error_held", 64'(ErrorM), 64'(1));
    chk("timeout_req_low", 64'(mem_req), 64'(0));
    hold_en = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("lane_queue_drained", 64'(lane_q.size()), 64'(0));
    chk("done_queue_drained", 64'(done_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
